// File: rtl/gol_pkg.sv
// Shared definitions for the Game-of-Life command sequencer: engine op codes,
// keypad codes, FSM states and the engine watchdog limit.
package gol_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_LOAD  = 2'd1,
        OP_STEP  = 2'd2,
        OP_CLEAR = 2'd3
    } gol_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } gol_state_e;

    localparam logic [3:0] KEY_LOAD   = 4'hA;
    localparam logic [3:0] KEY_RUN    = 4'hB;
    localparam logic [3:0] KEY_STEP   = 4'hC;
    localparam logic [3:0] KEY_CLEAR  = 4'hD;
    localparam logic [3:0] KEY_FASTER = 4'hE;
    localparam logic [3:0] KEY_SLOWER = 4'hF;

    localparam int unsigned WD_LIMIT = 256;
    localparam int unsigned WD_W     = 8;

    // Saturating speed adjust: never wraps past 0 or 7.
    function automatic logic [2:0] speed_adj(input logic [2:0] cur, input logic up);
        logic [2:0] res;
        if (up) begin
            res = (cur == 3'd7) ? cur : cur + 3'd1;
        end else begin
            res = (cur == 3'd0) ? cur : cur - 3'd1;
        end
        return res;
    endfunction

    // True on the last BUSY cycle the engine is allowed before timing out.
    function automatic logic wd_expired(input logic [WD_W-1:0] cnt);
        return cnt == WD_W'(WD_LIMIT - 1);
    endfunction

endpackage

// File: rtl/gol_step_timer.sv
// Auto-step timebase: prescaler producing timer slots, and a slot counter that
// pulses step_due once every (8 - speed) slots while running.
module gol_step_timer
    import gol_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       running,
    input  logic [2:0] speed,
    input  logic       restart,
    output logic       step_due
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] presc_q;
    logic [2:0]    slot_q;
    logic          step_due_q;
    logic          slot_s;

    assign slot_s   = (presc_q == PW'(TICK_DIV - 1));
    assign step_due = step_due_q;

    // Prescaler and slot counter; both held at zero while paused.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q    <= {PW{1'b0}};
            slot_q     <= 3'd0;
            step_due_q <= 1'b0;
        end else if (restart || !running) begin
            presc_q    <= {PW{1'b0}};
            slot_q     <= 3'd0;
            step_due_q <= 1'b0;
        end else begin
            step_due_q <= 1'b0;
            if (slot_s) begin
                presc_q <= {PW{1'b0}};
                if (slot_q == (3'd7 - speed)) begin
                    slot_q     <= 3'd0;
                    step_due_q <= 1'b1;
                end else begin
                    slot_q <= slot_q + 3'd1;
                end
            end else begin
                presc_q <= presc_q + PW'(1);
            end
        end
    end

endmodule

// File: rtl/gol_sequencer.sv
// Keypad-driven command sequencer for a Game-of-Life engine.
// Optional engine watchdog: define GOL_WATCHDOG_EN.
module gol_sequencer
    import gol_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned GEN_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_stb,
    input  logic [3:0]       key_code,
    output logic             eng_req,
    output logic [1:0]       eng_op,
    output logic [3:0]       eng_arg,
    input  logic             eng_ack,
    output logic             running,
    output logic [2:0]       speed,
    output logic [3:0]       sel_pattern,
    output logic [GEN_W-1:0] gen_count,
    output logic             err
);

    gol_state_e       state_q;
    logic             eng_req_q;
    gol_op_e          eng_op_q;
    logic [3:0]       eng_arg_q;
    logic [GEN_W-1:0] gen_q;

    logic             running_q, running_d;
    logic [2:0]       speed_q, speed_d;
    logic [3:0]       sel_q, sel_d;
    logic             step_pending_q, step_pending_d;

    logic             key_cmd_s;
    gol_op_e          key_op_s;
    logic             restart_s;
    logic             pause_s;
    logic             issue_step_s;
    logic             cmd_go_s;
    gol_op_e          cmd_op_s;
    logic [3:0]       cmd_arg_s;
    logic             step_due_s;

    gol_step_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .running  (running_q),
        .speed    (speed_q),
        .restart  (restart_s),
        .step_due (step_due_s)
    );

    // Key decode, local settings and the choice of the next engine command.
    always_comb begin
        key_cmd_s = 1'b0;
        key_op_s  = OP_NOP;
        running_d = running_q;
        speed_d   = speed_q;
        sel_d     = sel_q;
        if (key_stb) begin
            case (key_code)
                KEY_LOAD, KEY_CLEAR: begin
                    if (state_q == ST_IDLE) begin
                        key_cmd_s = 1'b1;
                        key_op_s  = (key_code == KEY_LOAD) ? OP_LOAD : OP_CLEAR;
                        running_d = 1'b0;
                    end else begin
                        key_cmd_s = 1'b0;
                    end
                end
                KEY_STEP: begin
                    if ((state_q == ST_IDLE) && !running_q) begin
                        key_cmd_s = 1'b1;
                        key_op_s  = OP_STEP;
                    end else begin
                        key_cmd_s = 1'b0;
                    end
                end
                KEY_RUN:    running_d = ~running_q;
                KEY_FASTER: speed_d   = speed_adj(speed_q, 1'b1);
                KEY_SLOWER: speed_d   = speed_adj(speed_q, 1'b0);
                default:    sel_d     = key_code;
            endcase
        end else begin
            sel_d = sel_q;
        end

        restart_s    = key_stb && (key_code == KEY_RUN) && !running_q;
        pause_s      = running_q && !running_d;
        issue_step_s = (state_q == ST_IDLE) && !key_cmd_s && step_pending_q && !pause_s;

        // A fresh step_due re-arms the flag even if this cycle issues the old one.
        if (!running_q || pause_s) begin
            step_pending_d = 1'b0;
        end else if (step_due_s) begin
            step_pending_d = 1'b1;
        end else if (issue_step_s) begin
            step_pending_d = 1'b0;
        end else begin
            step_pending_d = step_pending_q;
        end

        cmd_go_s  = key_cmd_s || issue_step_s;
        cmd_op_s  = key_cmd_s ? key_op_s : OP_STEP;
        cmd_arg_s = (key_cmd_s && (key_op_s == OP_LOAD)) ? sel_q : 4'd0;
    end

    // Local settings registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running_q      <= 1'b0;
            speed_q        <= 3'd3;
            sel_q          <= 4'd0;
            step_pending_q <= 1'b0;
        end else begin
            running_q      <= running_d;
            speed_q        <= speed_d;
            sel_q          <= sel_d;
            step_pending_q <= step_pending_d;
        end
    end

`ifdef GOL_WATCHDOG_EN
    logic [WD_W-1:0] wd_q;
    logic            err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Engine handshake FSM with registered command outputs and generation count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            eng_req_q <= 1'b0;
            eng_op_q  <= OP_NOP;
            eng_arg_q <= 4'd0;
            gen_q     <= {GEN_W{1'b0}};
`ifdef GOL_WATCHDOG_EN
            wd_q      <= {WD_W{1'b0}};
            err_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_go_s) begin
                        state_q   <= ST_BUSY;
                        eng_req_q <= 1'b1;
                        eng_op_q  <= cmd_op_s;
                        eng_arg_q <= cmd_arg_s;
`ifdef GOL_WATCHDOG_EN
                        wd_q      <= {WD_W{1'b0}};
`endif
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (eng_ack) begin
                        state_q   <= ST_IDLE;
                        eng_req_q <= 1'b0;
                        eng_op_q  <= OP_NOP;
                        eng_arg_q <= 4'd0;
                        if (eng_op_q == OP_STEP) begin
                            gen_q <= (gen_q == {GEN_W{1'b1}}) ? gen_q : gen_q + GEN_W'(1);
                        end else begin
                            gen_q <= {GEN_W{1'b0}};
                        end
`ifdef GOL_WATCHDOG_EN
                    end else if (wd_expired(wd_q)) begin
                        state_q   <= ST_IDLE;
                        eng_req_q <= 1'b0;
                        eng_op_q  <= OP_NOP;
                        eng_arg_q <= 4'd0;
                        err_q     <= 1'b1;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
`else
                    end else begin
                        state_q <= ST_BUSY;
                    end
`endif
                end
                default: begin
                    state_q   <= ST_IDLE;
                    eng_req_q <= 1'b0;
                    eng_op_q  <= OP_NOP;
                    eng_arg_q <= 4'd0;
                end
            endcase
        end
    end

    assign eng_req     = eng_req_q;
    assign eng_op      = eng_op_q;
    assign eng_arg     = eng_arg_q;
    assign running     = running_q;
    assign speed       = speed_q;
    assign sel_pattern = sel_q;
    assign gen_count   = gen_q;

endmodule
